// File: rtl/pwm_duty_meter.sv
// PWM high-time/period meter with stuck-input detection for PWM loopback self-test.
// Optional build macro PWM_METER_AVG_EN: report 4-period averages instead of per-period results.
module pwm_duty_meter #(
   parameter int bit_width = 8,
   parameter int CNT_W     = bit_width + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] high_out,
   output logic [CNT_W-1:0] period_out,
   output logic             valid,
   output logic             stuck,
   output logic             stuck_level
);
   typedef enum logic {ARM = 1'b0, MEASURE = 1'b1} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           state_q;
   logic             s1_q, s2_q, s3_q;
   logic [CNT_W-1:0] per_cnt_q, hi_cnt_q;
   logic [CNT_W-1:0] per_cnt_d, hi_cnt_d;
   logic             rise;

   assign rise      = s2_q & ~s3_q;
   assign per_cnt_d = per_cnt_q + CNT_ONE;
   assign hi_cnt_d  = hi_cnt_q + {{(CNT_W-1){1'b0}}, s2_q};

`ifdef PWM_METER_AVG_EN
   // Two extra bits hold the sum of four full-scale periods without overflow.
   logic [CNT_W+1:0] acc_hi_q, acc_per_q;
   logic [CNT_W+1:0] acc_hi_d, acc_per_d;
   logic [1:0]       idx_q;

   assign acc_hi_d  = acc_hi_q  + {2'b00, hi_cnt_q};
   assign acc_per_d = acc_per_q + {2'b00, per_cnt_q};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ARM;
         s1_q        <= 1'b0;
         s2_q        <= 1'b0;
         s3_q        <= 1'b0;
         per_cnt_q   <= '0;
         hi_cnt_q    <= '0;
         high_out    <= '0;
         period_out  <= '0;
         valid       <= 1'b0;
         stuck       <= 1'b0;
         stuck_level <= 1'b0;
`ifdef PWM_METER_AVG_EN
         acc_hi_q    <= '0;
         acc_per_q   <= '0;
         idx_q       <= '0;
`endif
      end else begin
         s1_q  <= pwm_in;
         s2_q  <= s1_q;
         s3_q  <= s2_q;
         valid <= 1'b0;
         if (rise) begin
            // The rise cycle itself is the first (high) cycle of the new period.
            per_cnt_q <= CNT_ONE;
            hi_cnt_q  <= CNT_ONE;
            if (state_q == ARM) begin
               stuck   <= 1'b0;
               state_q <= MEASURE;
            end else begin
`ifdef PWM_METER_AVG_EN
               idx_q <= idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  high_out   <= CNT_W'(acc_hi_d >> 2);
                  period_out <= CNT_W'(acc_per_d >> 2);
                  valid      <= 1'b1;
                  acc_hi_q   <= '0;
                  acc_per_q  <= '0;
               end else begin
                  acc_hi_q   <= acc_hi_d;
                  acc_per_q  <= acc_per_d;
               end
`else
               high_out   <= hi_cnt_q;
               period_out <= per_cnt_q;
               valid      <= 1'b1;
`endif
            end
         end else if (per_cnt_q == CNT_MAX) begin
            // Timeout fires before the counter can wrap; results keep their last values.
            stuck       <= 1'b1;
            stuck_level <= s2_q;
            state_q     <= ARM;
            per_cnt_q   <= '0;
            hi_cnt_q    <= '0;
`ifdef PWM_METER_AVG_EN
            acc_hi_q    <= '0;
            acc_per_q   <= '0;
            idx_q       <= '0;
`endif
         end else begin
            per_cnt_q <= per_cnt_d;
            hi_cnt_q  <= hi_cnt_d;
         end
      end
   end

endmodule

// File: doc/pwm_duty_meter.md
# pwm_duty_meter

Measures an incoming PWM waveform by counting its high time and period in `clk` cycles, reporting both with a one-cycle valid strobe. It is the receive-side companion to `pwm_module`: it recovers the programmed duty from the pin for loopback self-test of the GPU board's PWM outputs. It also flags a stuck-at-0/1 input (duty 0 or constant high).

## Interface
- `bit_width`, 8: duty resolution of the monitored generator.
- `CNT_W`, `bit_width+1`: counter and result width; holds a full 2^bit_width-cycle period.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pwm_in`  in  1  monitored PWM signal, asynchronous to `clk`.
- `high_out`  out  CNT_W  high-time of last completed period, in cycles.
- `period_out`  out  CNT_W  length of last completed period, in cycles.
- `valid`  out  1  one-cycle pulse when `high_out`/`period_out` update.
- `stuck`  out  1  no rising edge within timeout; level.
- `stuck_level`  out  1  synchronized `pwm_in` level captured at timeout.

## Operation
- Input path: 2-flop synchronizer `s1`,`s2`, then history flop `s3`; rise = `s2 & ~s3`.
- States: ARM (wait for first rise, no result) and MEASURE.
- ARM: on rise -> `per_cnt`=1, `hi_cnt`=1, clear `stuck`, go MEASURE; `valid` stays 0 (no complete period yet).
- MEASURE, rise: latch `period_out`<=`per_cnt`, `high_out`<=`hi_cnt`, pulse `valid`; then `per_cnt`=1, `hi_cnt`=1.
- MEASURE, no rise: `per_cnt`+=1; `hi_cnt`+=`s2`.
- Waveform high H cycles within period P (H<P) reports exactly H, P.
- Timeout: MEASURE with `per_cnt`==2^CNT_W-1 and no rise -> `stuck`<=1, `stuck_level`<=`s2`, go ARM; `high_out`/`period_out` hold last values; no `valid`.
- ARM counts `per_cnt` too; the same timeout in ARM sets/refreshes `stuck`, `stuck_level`, and stays ARM. `per_cnt` restarts at 0.
- Counters never wrap: the timeout fires first.
- Reset (any time, mid-period included): state ARM, all counters and outputs 0; the partial period is discarded.

## Timing
- Rise on `pwm_in` sampled at edge k is detected in cycle k+2; `valid` and new outputs are registered and appear in cycle k+3.
- `valid` high exactly one cycle per completed period (per 4 periods in AVG mode).
- Stuck detection latency: 2^CNT_W-1 cycles after the last rise/arm (511 at default).
- `stuck` deasserts in the cycle after the first detected rise.

## Configuration
- `PWM_METER_AVG_EN` defined: accumulate `hi_cnt`/`per_cnt` of 4 consecutive periods in CNT_W+2-bit accumulators. On the 4th completed period, output sums >>2 (truncate) and pulse `valid`. Timeout or reset clears accumulators and the period index.
- Undefined: per-period results as above; no accumulators are synthesized.

## Test plan
- `pwm_module` bit_width 8, max 255, duty 64, after reset -> first `valid` after second detected rise; every `valid` thereafter every 256 cycles with `high_out`=64, `period_out`=256; `stuck`=0.
- Sweep duty 1..255 (512 cycles each) -> last report per step `high_out`==duty, `period_out`==256.
- Duty 0 (pin constant 0) -> `stuck`=1, `stuck_level`=0 at 511 cycles after arm; no `valid`. Then duty 128 -> `stuck` clears one cycle after the rise; next `valid` reports 128/256.
- Pin forced constant 1 after running duty 100 -> `stuck`=1, `stuck_level`=1; `high_out`=100, `period_out`=256 held.
- Assert `rst_n` mid-period (duty 200) -> all outputs 0 immediately. After release, the first `valid` occurs only after two rises and reports 200/256.
- `PWM_METER_AVG_EN`, duty alternating 60/68 per period -> `valid` every 1024 cycles, `high_out`=64, `period_out`=256.
